// File: rtl/operand_forward_unit.sv
// Operand forwarding for the ID/EX boundary: resolves each source against EX/MEM/WB,
// flags load-use stalls and registers the resolved operands with hold and perf counters.
module operand_forward_unit #(
  parameter int XLEN    = 32,
  parameter int RA_W    = 5,
  parameter int NUM_SRC = 2,
  parameter int FWD_WB  = 1,
  parameter int CNT_W   = 32
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_id_valid,
  input  logic [NUM_SRC*RA_W-1:0] i_id_rs_addr,
  input  logic [NUM_SRC*XLEN-1:0] i_id_rs_data,
  input  logic                    i_ex_valid,
  input  logic                    i_ex_we,
  input  logic                    i_ex_is_load,
  input  logic [RA_W-1:0]         i_ex_rd,
  input  logic [XLEN-1:0]         i_ex_result,
  input  logic                    i_mem_valid,
  input  logic                    i_mem_we,
  input  logic                    i_mem_is_load,
  input  logic [RA_W-1:0]         i_mem_rd,
  input  logic [XLEN-1:0]         i_mem_alu,
  input  logic [XLEN-1:0]         i_mem_rdata,
  input  logic                    i_mem_rdata_valid,
  input  logic                    i_wb_valid,
  input  logic                    i_wb_we,
  input  logic [RA_W-1:0]         i_wb_rd,
  input  logic [XLEN-1:0]         i_wb_data,
  input  logic                    i_advance,
  output logic [NUM_SRC*XLEN-1:0] o_op_data,
  output logic                    o_op_valid,
  output logic [NUM_SRC*2-1:0]    o_fwd_src,
  output logic                    o_stall,
  output logic [CNT_W-1:0]        o_stall_cnt,
  output logic [CNT_W-1:0]        o_fwd_cnt
);

  localparam logic [CNT_W-1:0] CntOne = 1;

  logic [NUM_SRC*XLEN-1:0] w_opData;
  logic [NUM_SRC*2-1:0]    w_fwdSel;
  logic [NUM_SRC-1:0]      w_opStall;
  logic                    w_stall;
  logic                    w_anyFwd;
  logic                    w_issueFwd;

  logic [NUM_SRC*XLEN-1:0] r_opData;
  logic                    r_opValid;
  logic [NUM_SRC*2-1:0]    r_fwdSrc;
  logic [CNT_W-1:0]        r_stallCnt;
  logic [CNT_W-1:0]        r_fwdCnt;

  // The priority chain makes a stalling EX/MEM producer shadow any older match below it.
  for (genvar g = 0; g < NUM_SRC; g++) begin : gOperand
    logic [RA_W-1:0] w_rs;
    logic            w_rsNonZero;
    logic            w_hitEx;
    logic            w_hitMem;
    logic            w_hitWb;
    logic [XLEN-1:0] w_memValue;

    assign w_rs        = i_id_rs_addr[g*RA_W +: RA_W];
    assign w_rsNonZero = (w_rs != '0);
    assign w_hitEx     = i_ex_valid & i_ex_we & (i_ex_rd == w_rs) & w_rsNonZero;
    assign w_hitMem    = i_mem_valid & i_mem_we & (i_mem_rd == w_rs) & w_rsNonZero;
    assign w_hitWb     = (FWD_WB != 0) & i_wb_valid & i_wb_we & (i_wb_rd == w_rs) & w_rsNonZero;
    assign w_memValue  = i_mem_is_load ? i_mem_rdata : i_mem_alu;

    assign w_fwdSel[g*2 +: 2] = w_hitEx  ? 2'd1 :
                                w_hitMem ? 2'd2 :
                                w_hitWb  ? 2'd3 : 2'd0;

    assign w_opData[g*XLEN +: XLEN] = w_hitEx  ? i_ex_result :
                                      w_hitMem ? w_memValue  :
                                      w_hitWb  ? i_wb_data   :
                                                 i_id_rs_data[g*XLEN +: XLEN];

    assign w_opStall[g] = w_hitEx ? i_ex_is_load
                                  : (w_hitMem & i_mem_is_load & ~i_mem_rdata_valid);
  end

  assign w_stall    = i_id_valid & (|w_opStall);
  assign w_anyFwd   = |w_fwdSel;
  assign w_issueFwd = i_advance & ~w_stall & i_id_valid & w_anyFwd;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_opData   <= '0;
      r_opValid  <= 1'b0;
      r_fwdSrc   <= '0;
      r_stallCnt <= '0;
      r_fwdCnt   <= '0;
    end else begin
      if (i_advance) begin
        if (w_stall) begin
          r_opValid <= 1'b0;
          r_fwdSrc  <= '0;
        end else begin
          r_opData  <= w_opData;
          r_opValid <= i_id_valid;
          r_fwdSrc  <= w_fwdSel;
        end
      end
      if (w_stall && (r_stallCnt != '1)) begin
        r_stallCnt <= r_stallCnt + CntOne;
      end
      if (w_issueFwd && (r_fwdCnt != '1)) begin
        r_fwdCnt <= r_fwdCnt + CntOne;
      end
    end
  end

  assign o_op_data   = r_opData;
  assign o_op_valid  = r_opValid;
  assign o_fwd_src   = r_fwdSrc;
  assign o_stall     = w_stall;
  assign o_stall_cnt = r_stallCnt;
  assign o_fwd_cnt   = r_fwdCnt;

endmodule

// File: doc/operand_forward_unit.md
Name: operand_forward_unit

Overview:
- Parametrised successor to the pipeline's two-operand forwarding stage.
- Resolves operand hazards itself by comparing NUM_SRC ID-stage source addresses against the destination registers in EX, MEM and (optionally) WB.
- Selects the newest value per operand, detects load-use hazards and raises a stall.
- Registers the resolved operands into the ID/EX boundary with a downstream-advance hold and perf counters.

Parameters:
XLEN, 32, datapath width
RA_W, 5, register address width
NUM_SRC, 2, number of source operands resolved per instruction (1..3)
FWD_WB, 1, 1 = bypass the WB write value; 0 = regfile is write-before-read, so no WB bypass
CNT_W, 32, width of the saturating perf counters

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
id_valid  in  1  ID-stage instruction valid
id_rs_addr  in  NUM_SRC*RA_W  source addresses, operand i at [i*RA_W +: RA_W]
id_rs_data  in  NUM_SRC*XLEN  regfile read data, operand i at [i*XLEN +: XLEN]
ex_valid, ex_we, ex_is_load  in  1 each  EX-stage producer qualifiers
ex_rd  in  RA_W  EX destination
ex_result  in  XLEN  EX ALU result
mem_valid, mem_we, mem_is_load  in  1 each  MEM-stage qualifiers
mem_rd  in  RA_W  MEM destination
mem_alu  in  XLEN  MEM ALU result
mem_rdata  in  XLEN  load data
mem_rdata_valid  in  1  mem_rdata is valid this cycle
wb_valid, wb_we  in  1 each  WB qualifiers
wb_rd  in  RA_W  WB destination
wb_data  in  XLEN  WB write value
advance  in  1  downstream accepts the output register this cycle
op_data  out  NUM_SRC*XLEN  registered resolved operands
op_valid  out  1  registered: op_data holds a real instruction
fwd_src  out  NUM_SRC*2  registered per-operand source: 0 regfile, 1 EX, 2 MEM, 3 WB
stall  out  1  combinational: hold IF/ID this cycle
stall_cnt  out  CNT_W  saturating count of cycles with stall=1
fwd_cnt  out  CNT_W  saturating count of issued instructions with any fwd_src != 0

Behaviour:
- Reset (synchronous, checked on every clk edge, overrides all other updates):
  - op_data=0, op_valid=0, fwd_src=0, stall_cnt=0, fwd_cnt=0.
  - stall is combinational and has no reset value.
- Match rules for operand i against stage S:
  - hit_S = S_valid & S_we & (S_rd == rs_i) & (rs_i != 0).
  - Address 0 never forwards; its value comes from id_rs_data.
  - The WB match is used only when FWD_WB=1.
- Priority per operand: EX > MEM > WB > regfile. The newest producer always wins, including when all three stages match simultaneously.
- Forwarded value per source:
  - EX hit: ex_result.
  - MEM hit: mem_rdata if mem_is_load, else mem_alu.
  - WB hit: wb_data.
- Operand i needs to stall when either:
  - its highest-priority hit is EX with ex_is_load=1, or
  - its highest-priority hit is MEM with mem_is_load=1 and mem_rdata_valid=0.
- A lower-priority stage never satisfies an operand that a stalling higher-priority stage blocks.
- stall = id_valid & OR of the per-operand stall conditions. stall is independent of advance.
- Output register update on each clk edge (not in reset):
  - advance=0: op_data, op_valid and fwd_src hold their values.
  - advance=1, stall=1: insert a bubble. op_valid<=0, fwd_src<=0; op_data holds its value.
  - advance=1, stall=0: op_data<=resolved operands, op_valid<=id_valid, fwd_src<=selected sources.
- Latency: one cycle from ID inputs to op_data/op_valid.
- Upstream must keep the ID inputs stable while stall=1. The unit re-evaluates every cycle, so a multi-cycle load wait (mem_rdata_valid low for N cycles) yields N stall cycles.
- stall_cnt increments on every cycle where stall=1, saturating at all-ones.
- fwd_cnt increments when advance & ~stall & id_valid & (any fwd_src != 0), saturating at all-ones.
- Reset asserted during a stall: the bubble is discarded, the counters clear, and stall re-evaluates from the inputs on the following cycle.

Test Plan:
- Reset: hold reset 2 cycles, with stimulus on the inputs → op_valid=0, op_data=0, stall_cnt=0 and fwd_cnt=0 after the first edge.
- Priority: rs0=5; EX, MEM and WB all write x5 with ex_result=0x11, mem_alu=0x22, wb_data=0x33; rs1=6 with id_rs_data=0x66 → op_data={0x66,0x11}, fwd_src0=1, fwd_src1=0, fwd_cnt=1.
- Zero register: rs0=0, ex_rd=0, ex_we=1, ex_result=0xDEAD, id_rs_data0=0 → op_data0=0, fwd_src0=0.
- Load-use: EX load to x7, rs1=7 → stall=1 and a bubble (op_valid=0). Next cycle, with the load in MEM, mem_rdata_valid=0 for 2 cycles then 1 with mem_rdata=0xCAFE → stall_cnt=3, then op_data1=0xCAFE, fwd_src1=2, op_valid=1.
- Downstream hold: advance=0 for 3 cycles while the ID inputs change → op_data, op_valid and fwd_src unchanged; then advance=1 captures the current inputs.
- FWD_WB=0 build: WB-only match on rs0 with wb_data=0x44, id_rs_data0=0x40 → op_data0=0x40, fwd_src0=0. The same stimulus with FWD_WB=1 → op_data0=0x44, fwd_src0=3.
